// File: rtl/hazard_pkg.sv
// Shared constants, stage records and forward-select helper for the hazard unit.
// Pure declarations; no timing of its own.
// Not applicable to flow control; consumers decide stall/flush behaviour.
package hazard_pkg;

  // Operand source select for the Execute-stage ALU inputs (value 2'b11 is never produced)
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data (RD1E/RD2E)
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW from the writeback stage
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUOutM from the memory stage

  // R15 is the PC; it is never forwarded because reads of it see PC+8 directly
  localparam logic [3:0] PC_IDX = 4'd15;

  // Execute-stage shadow of the decode controls
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
  } e_stage_t;

  // Memory and writeback stages only need destination, write enable and PC-write flag
  typedef struct packed {
    logic [3:0] wa3;
    logic       reg_write;
    logic       pc_src;
  } mw_stage_t;

  // Pick the youngest in-flight producer of 'ra'; memory stage beats writeback
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic [3:0] wa_m, input logic rw_m,
                                         input logic [3:0] wa_w, input logic rw_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if ((ra == wa_m) && rw_m && (ra != PC_IDX)) begin
      sel = FWD_MEM;
    end else if ((ra == wa_w) && rw_w && (ra != PC_IDX)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side controls into, and stall/flush/forward selects out of, the hazard unit.
// Signals are combinational through the unit; zero-cycle path.
// No handshake: StallF/StallD are the backpressure the unit applies to the pipeline.
interface hazard_ctrl_if;

  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic [3:0] WA3D;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       PCSrcD;
  logic       BranchTakenE;

  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  // Datapath side: presents decode info, consumes hazard controls
  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  // Hazard unit side
  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/hazard_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Count visible one cycle after the enabling edge.
// No backpressure; holds at all-ones instead of wrapping, clear beats enable.
module hz_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already pinned at max
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state, zeroed asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use stall, PC-write and branch flushes.
// Hazard outputs are combinational (zero latency) from shadow state; counters lag one cycle.
// Applies backpressure via StallF/StallD; accepts none (no ready inputs).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  hazard_ctrl_if.slave    hz,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  e_stage_t  e_q, e_d;
  mw_stage_t m_q, m_d;
  mw_stage_t w_q, w_d;

  logic ldrstall;
  logic pc_wr_pending;
  logic flush_e_raw;
  logic flush_d_raw;
  logic stall_f_raw;

  // Hazard detection from current decode inputs and the shadow pipeline
  always_comb begin
    ldrstall      = e_q.mem_to_reg & e_q.reg_write &
                    ((hz.RA1D == e_q.wa3) | (hz.RA2D == e_q.wa3));
    pc_wr_pending = hz.PCSrcD | e_q.pc_src | m_q.pc_src;
    stall_f_raw   = ldrstall | pc_wr_pending;
    flush_d_raw   = pc_wr_pending | w_q.pc_src | hz.BranchTakenE;
    flush_e_raw   = ldrstall | hz.BranchTakenE;
  end

  // Outputs; StallF/FlushE are forced low during reset while FlushD still
  // reflects PCSrcD|BranchTakenE (shadow state is zero then)
  always_comb begin
    hz.StallF    = reset & stall_f_raw;
    hz.StallD    = reset & ldrstall;
    hz.FlushD    = flush_d_raw;
    hz.FlushE    = reset & flush_e_raw;
    hz.ForwardAE = fwd_sel(e_q.ra1, m_q.wa3, m_q.reg_write, w_q.wa3, w_q.reg_write);
    hz.ForwardBE = fwd_sel(e_q.ra2, m_q.wa3, m_q.reg_write, w_q.wa3, w_q.reg_write);
  end

  // Next shadow state: E captures decode unless flushed into a bubble, M/W always advance
  always_comb begin
    e_d.ra1        = hz.RA1D;
    e_d.ra2        = hz.RA2D;
    e_d.wa3        = hz.WA3D;
    e_d.reg_write  = hz.RegWriteD;
    e_d.mem_to_reg = hz.MemtoRegD;
    e_d.pc_src     = hz.PCSrcD;
    if (flush_e_raw) begin
      e_d = '0;
    end
    m_d.wa3       = e_q.wa3;
    m_d.reg_write = e_q.reg_write;
    m_d.pc_src    = e_q.pc_src;
    w_d           = m_q;
  end

  // Shadow pipeline registers; reset aborts any in-flight stall or flush immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Cycles spent stalling decode
  hz_sat_cnt #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (ldrstall),
    .cnt_o (stall_cnt)
  );

  // Cycles with any flush; D and E flushing together counts once
  hz_sat_cnt #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (flush_d_raw | flush_e_raw),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven check of hazard_ctrl plus hand sequences for
// counter saturation/clear and asynchronous reset mid-stall.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cnt_clr;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl_if hzif ();

  hazard_ctrl #(.CNTW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (hzif),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ra1, ra2, wa3;
    logic       rw, m2r, pcs, bt;
    logic       sf, sd, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                              input logic rw, input logic m2r, input logic pcs, input logic bt,
                              input logic sf, input logic sd, input logic fd, input logic fe,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3;
    v.rw = rw; v.m2r = m2r; v.pcs = pcs; v.bt = bt;
    v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
    v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic m2r, input logic pcs, input logic bt);
    hzif.RA1D = ra1; hzif.RA2D = ra2; hzif.WA3D = wa3;
    hzif.RegWriteD = rw; hzif.MemtoRegD = m2r; hzif.PCSrcD = pcs;
    hzif.BranchTakenE = bt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_st;
    int exp_fl;

    // ---- vector table: one row per cycle ----
    // ADD R1 then dependent ADD back-to-back -> MEM forward
    tbl[0]  = mk(6, 7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[1]  = mk(1, 3, 2, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // One independent instruction between -> WB forward
    tbl[4]  = mk(6, 7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[5]  = mk(8, 9, 10, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[6]  = mk(1, 3, 2, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b00);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // R15 never forwarded; B operand forwarded from WB
    tbl[9]  = mk(0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[10] = mk(0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[11] = mk(15, 5, 6, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    // Same register in M and W -> M wins
    tbl[13] = mk(0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[14] = mk(0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[15] = mk(3, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b10);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // LDR R4 ; ADD R5,R4,R4 -> one stall cycle, then WB forward on both
    tbl[19] = mk(13, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[20] = mk(4, 4, 5, 1, 0, 0, 0,  1, 1, 0, 1, 2'b00, 2'b00);
    tbl[21] = mk(4, 4, 5, 1, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b01, 2'b01);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // PC write: StallF 3 cycles, FlushD 4 cycles
    tbl[25] = mk(0, 0, 15, 1, 0, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 2'b00, 2'b00);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 2'b00, 2'b00);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2'b00, 2'b00);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // Branch taken together with load-use stall
    tbl[30] = mk(13, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[31] = mk(4, 4, 5, 1, 0, 0, 1,  1, 1, 1, 1, 2'b00, 2'b00);
    tbl[32] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    tbl[33] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    // Plain branch taken
    tbl[34] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 2'b00, 2'b00);
    tbl[35] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 2'b00);

    // ---- reset state ----
    reset   = 1'b0;
    cnt_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst StallF", hzif.StallF, 0);
    check("rst StallD", hzif.StallD, 0);
    check("rst FlushE", hzif.FlushE, 0);
    check("rst FlushD pcs|bt", hzif.FlushD, 1);
    check("rst ForwardAE", hzif.ForwardAE, 0);
    check("rst ForwardBE", hzif.ForwardBE, 0);
    check("rst stall_cnt", stall_cnt, 0);
    check("rst flush_cnt", flush_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst FlushD idle", hzif.FlushD, 0);
    reset = 1'b1;
    next_cycle();

    // ---- table ----
    exp_st = 0;
    exp_fl = 0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wa3, tbl[i].rw, tbl[i].m2r, tbl[i].pcs, tbl[i].bt);
      @(negedge clk);
      check($sformatf("row%0d StallF", i), hzif.StallF, tbl[i].sf);
      check($sformatf("row%0d StallD", i), hzif.StallD, tbl[i].sd);
      check($sformatf("row%0d FlushD", i), hzif.FlushD, tbl[i].fd);
      check($sformatf("row%0d FlushE", i), hzif.FlushE, tbl[i].fe);
      check($sformatf("row%0d ForwardAE", i), hzif.ForwardAE, tbl[i].fa);
      check($sformatf("row%0d ForwardBE", i), hzif.ForwardBE, tbl[i].fb);
      check($sformatf("row%0d stall_cnt", i), stall_cnt, exp_st);
      check($sformatf("row%0d flush_cnt", i), flush_cnt, exp_fl);
      exp_st += int'(tbl[i].sd);
      exp_fl += int'(tbl[i].fd | tbl[i].fe);
      next_cycle();
    end
    check("table stall_cnt", stall_cnt, 2);
    check("table flush_cnt", flush_cnt, 7);

    // ---- flush counter saturation ----
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (65527) @(posedge clk);
    #1;
    check("sat flush_cnt near max", flush_cnt, 16'hFFFE);
    repeat (70000 - 65527) @(posedge clk);
    #1;
    check("sat flush_cnt held", flush_cnt, 16'hFFFF);
    check("sat stall_cnt untouched", stall_cnt, 2);

    // ---- cnt_clr wins over a simultaneous stall/flush ----
    drive(13, 0, 4, 1, 1, 0, 0);
    next_cycle();
    drive(4, 4, 5, 1, 0, 0, 0);
    cnt_clr = 1'b1;
    @(negedge clk);
    check("clr StallD", hzif.StallD, 1);
    check("clr FlushE", hzif.FlushE, 1);
    check("clr flush_cnt before", flush_cnt, 16'hFFFF);
    next_cycle();
    cnt_clr = 1'b0;
    check("clr stall_cnt", stall_cnt, 0);
    check("clr flush_cnt", flush_cnt, 0);

    // ---- reset asserted mid-stall ----
    drive(4, 0, 4, 1, 1, 0, 0);
    @(negedge clk);
    check("mid c1 StallD", hzif.StallD, 0);
    next_cycle();
    @(negedge clk);
    check("mid c2 StallD", hzif.StallD, 1);
    next_cycle();
    check("mid c2 stall_cnt", stall_cnt, 1);
    @(negedge clk);
    check("mid c3 StallD", hzif.StallD, 0);
    next_cycle();
    @(negedge clk);
    check("mid c4 StallF", hzif.StallF, 1);
    #2;
    reset = 1'b0;
    hzif.BranchTakenE = 1'b1;
    #1;
    check("async StallF", hzif.StallF, 0);
    check("async StallD", hzif.StallD, 0);
    check("async FlushE", hzif.FlushE, 0);
    check("async FlushD", hzif.FlushD, 1);
    check("async ForwardAE", hzif.ForwardAE, 0);
    check("async ForwardBE", hzif.ForwardBE, 0);
    check("async stall_cnt", stall_cnt, 0);
    check("async flush_cnt", flush_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("release StallF", hzif.StallF, 0);
    check("release StallD", hzif.StallD, 0);
    check("release FlushE", hzif.FlushE, 0);
    next_cycle();
    @(negedge clk);
    check("post StallD", hzif.StallD, 0);
    check("post FlushD", hzif.FlushD, 0);
    check("post stall_cnt", stall_cnt, 0);
    check("post flush_cnt", flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
